// File: rtl/s4_pkg.sv
// Shared FP16 types and ordering helpers for the S4 max-pool stage.
package s4_pkg;

  localparam int FP16_W = 16;

  typedef logic [FP16_W-1:0] fp16_t;

  // Map an FP16 bit pattern to an unsigned key whose integer order matches
  // numeric order. Negative values are inverted so larger magnitudes sort
  // lower, and positive values get their sign bit set so they sort above
  // every negative value. This also places -0 just below +0.
  function automatic fp16_t fp16_key(fp16_t x);
    return x[15] ? ~x : (x ^ 16'h8000);
  endfunction

  // Larger of two FP16 values. On a tie the first operand wins.
  function automatic fp16_t fp16_max(fp16_t a, fp16_t b);
    return (fp16_key(b) > fp16_key(a)) ? b : a;
  endfunction

endpackage

// File: rtl/fp16_max2.sv
// Combinational two-input FP16 maximum. When both inputs are equal, a is returned.
module fp16_max2
  import s4_pkg::*;
(
  input  fp16_t a,
  input  fp16_t b,
  output fp16_t y
);

  assign y = fp16_max(a, b);

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 FP16 max-pool over a CHANNELS x H x W frame.
// Even rows fold each horizontal pair into a half-width row buffer. On odd
// rows, the stored pair is folded with the new pair, and the window result
// is emitted on the bottom-right element.
module maxpool2x2_stream
  import s4_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int H          = 10,
  parameter int W          = 10,
  parameter int CHANNELS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done
);

  localparam int COL_W = (W > 1) ? $clog2(W) : 1;
  localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int IDX_W = ((W / 2) > 1) ? $clog2(W / 2) : 1;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(H - 1);
  localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(CHANNELS - 1);

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [CH_W-1:0]       ch;
  logic [DATA_WIDTH-1:0] h;
  logic [DATA_WIDTH-1:0] rowbuf [W/2];
  logic [IDX_W-1:0]      idx;
  logic                  out_last;
  fp16_t                 max_h;
  fp16_t                 max_buf;
  logic                  xfer_in;
  logic                  xfer_out;
  logic                  produce;
  logic                  col_end;
  logic                  row_end;
  logic                  last_win;

  assign in_ready = ~out_valid | out_ready;
  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;
  assign produce  = xfer_in & row[0] & col[0];
  assign col_end  = (col == COL_MAX);
  assign row_end  = (row == ROW_MAX);
  assign last_win = col_end & row_end & (ch == CH_MAX);
  assign idx      = IDX_W'(col >> 1);

  // The horizontal fold and the final window fold both compare against h.
  fp16_max2 u_max_h (
    .a (h),
    .b (in_data),
    .y (max_h)
  );

  // The odd-row, even-column fold compares against the stored row-buffer pair.
  fp16_max2 u_max_buf (
    .a (rowbuf[idx]),
    .b (in_data),
    .y (max_buf)
  );

  // Position counters, output register and frame-done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      ch         <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= xfer_out & out_last;
      if (xfer_in) begin
        if (col_end) begin
          col <= '0;
          if (row_end) begin
            row <= '0;
            ch  <= (ch == CH_MAX) ? '0 : ch + 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
      if (produce) begin
        out_valid <= 1'b1;
        out_data  <= max_h;
        out_last  <= last_win;
      end else if (xfer_out) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Partial-window datapath. This state is always written before it is read
  // within a window, so it needs no reset.
  always_ff @(posedge clk) begin
    if (xfer_in) begin
      if (!row[0]) begin
        if (!col[0]) h <= in_data;
        else         rowbuf[idx] <= max_h;
      end else if (!col[0]) begin
        h <= max_buf;
      end
    end
  end

endmodule
